// File: rtl/aoi21_updown_counter.sv
// 4-bit synchronous up/down counter built entirely from switch-level CMOS.
// Next-state: q ^ toggle, where the toggle ripples through "all lower bits
// match the direction" (all ones when counting up, all zeros when down).
// Load and reset are folded in as a mux plus a NOR gate in front of each D
// input, so reset is purely synchronous.

module aoi21_updown_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc
);

  // w_t[i] is the toggle enable for bit i (w_t[0] is simply en)
  wire [4:1] w_t;
  wire [4:1] w_tn;
  wire [3:0] w_qunor;
  wire [3:0] w_qux;
  wire [3:0] w_x;
  wire [3:0] w_tnor;
  wire [3:0] w_n;
  wire [3:0] w_nn;
  wire [3:0] w_keep;
  wire [3:0] w_mb;
  wire [3:0] w_dff;
  wire       w_nlr;
  wire       w_tcn;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      wire w_tg;

      // w_x = 1 when this bit would not stop a carry/borrow: q XNOR up
      cmos_nor2 u_qunor (.Y(w_qunor[i]), .A(q[i]), .B(up));
      aoi21     u_qux   (.Y(w_qux[i]), .A(q[i]), .B(up), .C(w_qunor[i]));
      cmos_inv  u_x     (.Y(w_x[i]), .A(w_qux[i]));

      if (i == 0) begin : g_t0
        cmos_buf u_tg (.Y(w_tg), .A(en));
      end else begin : g_tn
        cmos_buf u_tg (.Y(w_tg), .A(w_t[i]));
      end

      // toggle ripple to the next bit: t[i+1] = t[i] & x[i]
      cmos_nand2 u_tn (.Y(w_tn[i+1]), .A(w_tg), .B(w_x[i]));
      cmos_inv   u_t  (.Y(w_t[i+1]), .A(w_tn[i+1]));

      // count value: q ^ toggle
      cmos_nor2 u_tnor (.Y(w_tnor[i]), .A(q[i]), .B(w_tg));
      aoi21     u_n    (.Y(w_n[i]), .A(q[i]), .B(w_tg), .C(w_tnor[i]));
      cmos_inv  u_nn   (.Y(w_nn[i]), .A(w_n[i]));

      // load mux, inverted: mb = ~((load & d) | (~load & n))
      cmos_nor2 u_keep (.Y(w_keep[i]), .A(load), .B(w_nn[i]));
      aoi21     u_mux  (.Y(w_mb[i]), .A(load), .B(d[i]), .C(w_keep[i]));

      // reset gating on D: D = ~rst & mux
      cmos_nor2 u_rst (.Y(w_dff[i]), .A(rst), .B(w_mb[i]));

      msff u_ff (.Q(q[i]), .D(w_dff[i]), .CLK(clk));
    end
  endgenerate

  // terminal count: full ripple through all four bits, qualified by ~load & ~rst
  cmos_nor2  u_nlr (.Y(w_nlr), .A(load), .B(rst));
  cmos_nand2 u_tcn (.Y(w_tcn), .A(w_t[4]), .B(w_nlr));
  cmos_inv   u_tc  (.Y(tc), .A(w_tcn));

endmodule

// Leaf cell: Y = ~((A & B) | C), six transistors.
module aoi21 (
  output wire Y,
  input  wire A,
  input  wire B,
  input  wire C
);
  supply1 vdd;
  supply0 gnd;
  wire w_pu;
  wire w_pd;

  // pull-up: C in series with (A || B)
  pmos p_c (w_pu, vdd, C);
  pmos p_a (Y, w_pu, A);
  pmos p_b (Y, w_pu, B);
  // pull-down: (A series B) in parallel with C
  nmos n_b (w_pd, gnd, B);
  nmos n_a (Y, w_pd, A);
  nmos n_c (Y, gnd, C);
endmodule

// Static CMOS inverter.
module cmos_inv (
  output wire Y,
  input  wire A
);
  supply1 vdd;
  supply0 gnd;
  pmos p_a (Y, vdd, A);
  nmos n_a (Y, gnd, A);
endmodule

// Non-inverting buffer (two inverters), used to rename a signal without assign.
module cmos_buf (
  output wire Y,
  input  wire A
);
  wire w_ab;
  cmos_inv u_i0 (.Y(w_ab), .A(A));
  cmos_inv u_i1 (.Y(Y), .A(w_ab));
endmodule

// Static CMOS NAND2.
module cmos_nand2 (
  output wire Y,
  input  wire A,
  input  wire B
);
  supply1 vdd;
  supply0 gnd;
  wire w_pd;
  pmos p_a (Y, vdd, A);
  pmos p_b (Y, vdd, B);
  nmos n_b (w_pd, gnd, B);
  nmos n_a (Y, w_pd, A);
endmodule

// Static CMOS NOR2.
module cmos_nor2 (
  output wire Y,
  input  wire A,
  input  wire B
);
  supply1 vdd;
  supply0 gnd;
  wire w_pu;
  pmos p_a (w_pu, vdd, A);
  pmos p_b (Y, w_pu, B);
  nmos n_a (Y, gnd, A);
  nmos n_b (Y, gnd, B);
endmodule

// Positive-edge master-slave flip-flop with transmission gates.
// Master follows D while CLK = 0 and recirculates while CLK = 1; the slave
// does the opposite. Each storage node is always driven by exactly one
// transmission gate fed from a static inverter or from D.
module msff (
  output wire Q,
  input  wire D,
  input  wire CLK
);
  wire w_clkb;
  wire w_m;
  wire w_mb;
  wire w_mf;
  wire w_s;
  wire w_sfb;

  cmos_inv u_ck (.Y(w_clkb), .A(CLK));

  // master: input gate open on CLK = 0, feedback gate open on CLK = 1
  nmos n_mi (w_m, D, w_clkb);
  pmos p_mi (w_m, D, CLK);
  cmos_inv u_m1 (.Y(w_mb), .A(w_m));
  cmos_inv u_m2 (.Y(w_mf), .A(w_mb));
  nmos n_mf (w_m, w_mf, CLK);
  pmos p_mf (w_m, w_mf, w_clkb);

  // slave: input gate open on CLK = 1, feedback gate open on CLK = 0
  nmos n_si (w_s, w_mb, CLK);
  pmos p_si (w_s, w_mb, w_clkb);
  cmos_inv u_s1 (.Y(Q), .A(w_s));
  cmos_inv u_s2 (.Y(w_sfb), .A(Q));
  nmos n_sf (w_s, w_sfb, w_clkb);
  pmos p_sf (w_s, w_sfb, CLK);
endmodule

// File: tb/tb_aoi21_updown_counter.sv
// Scoreboard bench for aoi21_updown_counter: stimulus applies inputs on the
// falling edge and queues expectations from an arithmetic model; monitors
// compare tc before the rising edge and q/tc after it.

module tb_aoi21_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = 4'h0;
  logic [3:0] q;
  logic       tc;

  aoi21_updown_counter dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .up  (up),
    .load(load),
    .d   (d),
    .q   (q),
    .tc  (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    string      tag;
  } post_t;

  typedef struct {
    logic  tc;
    string tag;
  } pre_t;

  post_t post_q[$];
  pre_t  pre_q[$];

  int checks = 0;
  int errors = 0;
  int mq = 0;
  bit mvalid = 0;

  function automatic logic model_tc(input int cq, input bit r, input bit l, input bit e, input bit u);
    if (r || l || !e) return 1'b0;
    if (u) return (cq == 15);
    return (cq == 0);
  endfunction

  // apply one cycle of inputs and queue the expected responses
  task automatic step(input bit r, input bit l, input bit e, input bit u, input logic [3:0] dv, input string tag);
    pre_t  p;
    post_t s;
    int    nq;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; d = dv;
    if (mvalid || r || l || !e) begin
      p.tc = model_tc(mq, r, l, e, u);
      p.tag = tag;
      pre_q.push_back(p);
    end
    if (r) nq = 0;
    else if (l) nq = int'(dv);
    else if (e) nq = u ? (mq + 1) % 16 : (mq + 15) % 16;
    else nq = mq;
    if (r) mvalid = 1;
    if (mvalid) begin
      mq = nq;
      s.q = 4'(mq);
      s.tc = model_tc(mq, r, l, e, u);
      s.tag = tag;
      post_q.push_back(s);
    end
  endtask

  // pre-edge monitor: tc is combinational from current q and inputs
  initial begin
    pre_t p;
    forever begin
      @(negedge clk);
      #2;
      if (pre_q.size() > 0) begin
        p = pre_q.pop_front();
        checks++;
        if ($isunknown(tc) || tc !== p.tc) begin
          errors++;
          $display("FAIL %s pre-edge tc: got %b expected %b (q=%h)", p.tag, tc, p.tc, q);
        end
      end
    end
  end

  // post-edge monitor: q and tc after each rising edge
  initial begin
    post_t s;
    forever begin
      @(posedge clk);
      #1;
      if (post_q.size() > 0) begin
        s = post_q.pop_front();
        checks++;
        if ($isunknown({q, tc}) || q !== s.q || tc !== s.tc) begin
          errors++;
          $display("FAIL %s post-edge: got q=%h tc=%b expected q=%h tc=%b", s.tag, q, tc, s.q, s.tc);
        end
      end
    end
  end

  initial begin
    int r;
    // reset overrides load/en/d
    step(1, 1, 1, 1, 4'hA, "reset");
    // up count through wrap
    for (int k = 0; k < 16; k++) step(0, 0, 1, 1, 4'h0, "up_wrap");
    // down wrap from 1
    step(0, 1, 0, 0, 4'h1, "load1");
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 4'h0, "down_wrap");
    // load priority then hold
    step(0, 1, 0, 1, 4'h5, "load5");
    step(0, 1, 1, 1, 4'h9, "load_over_en");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 4'h3, "hold");
    // mid-count reset
    step(0, 1, 0, 1, 4'hC, "load12");
    step(0, 0, 1, 1, 4'h0, "count13");
    step(1, 0, 1, 1, 4'h7, "mid_reset");
    step(0, 0, 1, 1, 4'h0, "after_reset");
    // direction toggle
    step(0, 1, 0, 0, 4'h7, "load7");
    step(0, 0, 1, 1, 4'h0, "tog_up");
    step(0, 0, 1, 0, 4'h0, "tog_dn");
    step(0, 0, 1, 1, 4'h0, "tog_up");
    step(0, 0, 1, 0, 4'h0, "tog_dn");
    // boundary: load 0 then count down with tc, load 15 count up
    step(0, 1, 1, 0, 4'h0, "load0");
    step(0, 0, 1, 0, 4'h0, "dn_from0");
    step(0, 1, 1, 1, 4'hF, "loadF");
    step(0, 0, 1, 1, 4'h0, "up_fromF");
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      step(r < 4, (r >= 4) && (r < 18), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), "random");
    end
    // drain: give monitors time to consume the last expectations
    @(posedge clk);
    #3;
    checks++;
    if (post_q.size() != 0 || pre_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", post_q.size(), pre_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
